mult_accum_pipe: RTL and testbench
==================================

// Module: mult_accum_pipe
// PURPOSE
//  Parametrised, pipelined signed/unsigned multiply-accumulate for the VERA FX datapath; successor to the
//  single-accumulator 16x16 MAC. Adds configurable widths, NUM_ACC independent accumulators, a valid/ready
//  handshake with backpressure, optional saturation and a sticky overflow flag. Sits between the FX register
//  file (operand source) and the VRAM write path (result sink).
// PARAMETERS
//  DATA_W    16  operand width (A and B)
//  ACC_W     32  accumulator/result width; must be >= 2*DATA_W
//  NUM_ACC   2   number of independent accumulators (>=1)
//  SATURATE  0   1: clamp results to signed ACC_W range; 0: two's-complement wrap
// PORTS
//  clk          in   1               clock
//  rst_n        in   1               asynchronous active-low reset
//  in_valid     in   1               operand/op valid
//  in_ready     out  1               block can accept an op this cycle
//  input_a      in   DATA_W          operand A
//  input_b      in   DATA_W          operand B
//  acc_sel      in   clog2(NUM_ACC)  target accumulator (width 1 when NUM_ACC==1)
//  is_signed    in   1               1: signed multiply; 0: unsigned
//  mult_enabled in   1               1: term = A*B; 0: term = {B,A} zero-extended (pass-through load)
//  reset_accum  in   1               clear target accumulator and its overflow flag
//  accumulate   in   1               1: acc +/- term; 0: acc = term
//  add_or_sub   in   1               0: add; 1: subtract (only when accumulate=1)
//  out_valid    out  1               result valid
//  out_ready    in   1               sink accepts result
//  output_acc   out  ACC_W           updated accumulator value
//  out_sel      out  clog2(NUM_ACC)  accumulator the result belongs to
//  overflow     out  1               sticky overflow flag of out_sel accumulator
// BEHAVIOUR
//  - Reset (rst_n=0, async): all accumulators, ovf flags, stage valids = 0; out_valid=0, output_acc=0,
//    out_sel=0, overflow=0. in_ready rises the first clk after release.
//  - 3-stage pipe: S1 registers operands+ctrl; S2 registers term (product or pass-through), ACC_W bits,
//    sign-extended if is_signed & mult_enabled; S3 updates accumulator and registers output.
//  - Global stall: adv = !out_valid | out_ready; in_ready = adv. All stages move only when adv=1;
//    op accepted when in_valid & in_ready. Latency 3 cycles accept->out_valid with out_ready held 1.
//    Throughput 1 op/cycle. Bubbles propagate as invalid stages; no state change for invalid stages.
//  - S3 update priority per op (target = acc[sel]): reset_accum -> acc=0, ovf=0, result 0;
//    else accumulate -> acc = acc +/- term; else acc = term (ovf unchanged on load).
//  - Read-modify-write of acc happens entirely in S3, so back-to-back ops on same acc_sel need no forwarding.
//  - Overflow: signed overflow of the ACC_W add/sub sets ovf[sel] (sticky). SATURATE=1: result clamps to
//    2^(ACC_W-1)-1 or -2^(ACC_W-1); SATURATE=0: wraps. Cleared only by reset_accum on that acc or rst_n.
//  - Backpressure: while out_valid & !out_ready, output_acc/out_sel/overflow hold stable, no acc updates.
//  - acc_sel >= NUM_ACC: op is consumed, out_valid asserted, output_acc=0, no state change.
//  - rst_n asserted mid-operation discards all in-flight ops; no partial results emitted.
// STRUCTURE
//  - Shared package vera_fx_pkg: mac_op_t struct {is_signed, mult_enabled, reset_accum, accumulate,
//    add_or_sub, sel}, ACC_W-related min/max constant functions.
//  - Sub-module mult_accum_sat: combinational ACC_W add/sub with overflow detect and optional clamp.
//  - Multiplier inferred in S1->S2 (maps to SB_MAC16 on iCE40); accumulator array held in flops.
// TESTING
//  1. Reset then op A=3,B=-4 signed, mult, accumulate=0, sel0 -> 3 cycles later output_acc=-12, out_sel=0.
//  2. Four back-to-back ops A=0x0100,B=0x0010 accumulate add sel0 after clear -> outputs 0x1000,0x2000,
//     0x3000,0x4000 on consecutive cycles.
//  3. Interleave sel0 (+5*5) and sel1 (-2*7 sub) ops -> acc0 and acc1 evolve independently (25,50 / 14,28).
//  4. SATURATE=1, acc0=0x7FFF_FFF0, add term 0x100 -> output 0x7FFF_FFFF, overflow=1; next reset_accum
//     -> 0, overflow=0.
//  5. out_ready=0 for 5 cycles with 3 ops in flight -> in_ready=0, output stable, no op lost; release ->
//     results in order. mult_enabled=0, A=0x1234,B=0xABCD -> 0xABCD1234.
//  6. Pulse rst_n low with 2 ops in flight -> out_valid=0 immediately, no stale result after release.

Source files
------------

// File: rtl/vera_fx_pkg.sv
// Shared VERA FX datapath types: the per-op control bundle carried down the MAC pipe
// and helpers giving the signed saturation bounds of an accumulator width.
package vera_fx_pkg;

  localparam int SEL_MAX_W = 8;
  localparam int CONST_W   = 128;

  typedef struct packed {
    logic                 is_signed;
    logic                 mult_enabled;
    logic                 reset_accum;
    logic                 accumulate;
    logic                 add_or_sub;
    logic [SEL_MAX_W-1:0] sel;
  } mac_op_t;

  // Bit patterns of the most positive / most negative value of an acc_w-bit signed number.
  function automatic logic [CONST_W-1:0] acc_max(input int acc_w);
    return (CONST_W'(1) << (acc_w - 1)) - CONST_W'(1);
  endfunction

  function automatic logic [CONST_W-1:0] acc_min(input int acc_w);
    return CONST_W'(1) << (acc_w - 1);
  endfunction

endpackage

// File: rtl/mult_accum_sat.sv
// Combinational ACC_W add/subtract with signed-overflow detection and optional clamping
// to the signed ACC_W range.
module mult_accum_sat
  import vera_fx_pkg::*;
#(
  parameter int ACC_W    = 32,
  parameter int SATURATE = 0
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] term,
  input  logic             sub,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);

  localparam logic [ACC_W-1:0] MAX_V = ACC_W'(acc_max(ACC_W));
  localparam logic [ACC_W-1:0] MIN_V = ACC_W'(acc_min(ACC_W));

  logic [ACC_W-1:0] raw;

  // On overflow the true result always carries the sign of acc, which picks the clamp rail.
  always_comb begin
    raw = sub ? (acc - term) : (acc + term);
    if (sub) begin
      ovf = (acc[ACC_W-1] != term[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
    end else begin
      ovf = (acc[ACC_W-1] == term[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
    end
    result = raw;
    if ((SATURATE != 0) && ovf) begin
      result = acc[ACC_W-1] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/mult_accum_pipe.sv
// Three-stage pipelined multiply-accumulate with NUM_ACC independent accumulators,
// valid/ready flow control, optional saturation and per-accumulator sticky overflow.
module mult_accum_pipe
  import vera_fx_pkg::*;
#(
  parameter int  DATA_W   = 16,
  parameter int  ACC_W    = 32,
  parameter int  NUM_ACC  = 2,
  parameter int  SATURATE = 0,
  localparam int SEL_W    = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] input_a,
  input  logic [DATA_W-1:0] input_b,
  input  logic [SEL_W-1:0]  acc_sel,
  input  logic              is_signed,
  input  logic              mult_enabled,
  input  logic              reset_accum,
  input  logic              accumulate,
  input  logic              add_or_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  output_acc,
  output logic [SEL_W-1:0]  out_sel,
  output logic              overflow
);

  // Handshake: an op transfers on a clk edge where in_valid & in_ready; a result transfers
  // where out_valid & out_ready. The whole pipe advances together only when the output
  // register is empty or being drained (adv); in_ready is held low until the first edge after reset.
  logic ready_q, adv, accept;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_a, s1_b;
  mac_op_t           s1_op, in_op;

  logic              s2_valid;
  logic [ACC_W-1:0]  s2_term;
  mac_op_t           s2_op;

  logic [ACC_W-1:0]  acc_q [NUM_ACC];
  logic [NUM_ACC-1:0] ovf_q;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && ready_q;
  assign accept   = in_valid && in_ready;

  always_comb begin
    in_op              = '0;
    in_op.is_signed    = is_signed;
    in_op.mult_enabled = mult_enabled;
    in_op.reset_accum  = reset_accum;
    in_op.accumulate   = accumulate;
    in_op.add_or_sub   = add_or_sub;
    in_op.sel          = SEL_MAX_W'(acc_sel);
  end

  // S1: operand and control capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q  <= 1'b0;
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else begin
      ready_q <= 1'b1;
      if (adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_a  <= input_a;
          s1_b  <= input_b;
          s1_op <= in_op;
        end
      end
    end
  end

  // One multiplier serves both modes: operands are sign- or zero-extended before the multiply.
  logic [2*DATA_W-1:0] ext_a, ext_b, prod;
  logic [ACC_W-1:0]    term_d;

  always_comb begin
    ext_a = {{DATA_W{s1_op.is_signed & s1_a[DATA_W-1]}}, s1_a};
    ext_b = {{DATA_W{s1_op.is_signed & s1_b[DATA_W-1]}}, s1_b};
    prod  = ext_a * ext_b;
    if (!s1_op.mult_enabled) begin
      term_d = ACC_W'({s1_b, s1_a});
    end else if (s1_op.is_signed) begin
      term_d = ACC_W'($signed(prod));
    end else begin
      term_d = ACC_W'(prod);
    end
  end

  // S2: term register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_term  <= '0;
      s2_op    <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_term <= term_d;
        s2_op   <= s1_op;
      end
    end
  end

  logic [SEL_W-1:0] sel_idx;
  logic             in_range, ovf_cur, sum_ovf;
  logic [ACC_W-1:0] acc_cur, sum;

  always_comb begin
    sel_idx  = s2_op.sel[SEL_W-1:0];
    in_range = (s2_op.sel < SEL_MAX_W'(NUM_ACC));
    acc_cur  = '0;
    ovf_cur  = 1'b0;
    if (in_range) begin
      acc_cur = acc_q[sel_idx];
      ovf_cur = ovf_q[sel_idx];
    end
  end

  mult_accum_sat #(
    .ACC_W   (ACC_W),
    .SATURATE(SATURATE)
  ) u_sat (
    .acc   (acc_cur),
    .term  (s2_term),
    .sub   (s2_op.add_or_sub),
    .result(sum),
    .ovf   (sum_ovf)
  );

  // S3: accumulator read-modify-write and output register; an out-of-range select yields 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
      ovf_q      <= '0;
      out_valid  <= 1'b0;
      output_acc <= '0;
      out_sel    <= '0;
      overflow   <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_sel <= sel_idx;
        if (!in_range || s2_op.reset_accum) begin
          output_acc <= '0;
          overflow   <= 1'b0;
          if (in_range) begin
            acc_q[sel_idx] <= '0;
            ovf_q[sel_idx] <= 1'b0;
          end
        end else if (s2_op.accumulate) begin
          acc_q[sel_idx] <= sum;
          ovf_q[sel_idx] <= ovf_cur | sum_ovf;
          output_acc     <= sum;
          overflow       <= ovf_cur | sum_ovf;
        end else begin
          acc_q[sel_idx] <= s2_term;
          output_acc     <= s2_term;
          overflow       <= ovf_cur;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_accum_pipe.sv
// Scoreboard bench for mult_accum_pipe: directed scenarios plus randomized ops with
// random backpressure, checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_mult_accum_pipe;

  localparam int DATA_W   = 16;
  localparam int ACC_W    = 32;
  localparam int NUM_ACC  = 3;
  localparam int SATURATE = 1;
  localparam int SEL_W    = 2;
  localparam int EW       = ACC_W + SEL_W + 1;
  localparam longint MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (ACC_W - 1));

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] input_a, input_b;
  logic [SEL_W-1:0]  acc_sel;
  logic              is_signed, mult_enabled, reset_accum, accumulate, add_or_sub;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  output_acc;
  logic [SEL_W-1:0]  out_sel;
  logic              overflow;

  mult_accum_pipe #(
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W),
    .NUM_ACC (NUM_ACC),
    .SATURATE(SATURATE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .input_a     (input_a),
    .input_b     (input_b),
    .acc_sel     (acc_sel),
    .is_signed   (is_signed),
    .mult_enabled(mult_enabled),
    .reset_accum (reset_accum),
    .accumulate  (accumulate),
    .add_or_sub  (add_or_sub),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .output_acc  (output_acc),
    .out_sel     (out_sel),
    .overflow    (overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  longint acc_m[NUM_ACC];
  logic   ovf_m[NUM_ACC];
  int     bp_mode;   // 0: always ready, 1: random, 2: stalled

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic longint wrap_acc(input longint x);
    longint m, v;
    m = longint'(1) <<< ACC_W;
    v = x & (m - 1);
    if (v >= (m >>> 1)) v = v - m;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_ACC; i++) begin
      acc_m[i] = 0;
      ovf_m[i] = 1'b0;
    end
  endtask

  // Reference: compute the op's effect with plain integer arithmetic and queue the result.
  task automatic model_issue(input logic [15:0] a, input logic [15:0] b, input int sel,
                             input logic sgn, input logic mul, input logic rac,
                             input logic accum, input logic sub);
    longint t, r;
    logic [SEL_W-1:0] sb;
    sb = SEL_W'(sel);
    if (sel >= NUM_ACC || rac) begin
      if (sel < NUM_ACC) begin
        acc_m[sel] = 0;
        ovf_m[sel] = 1'b0;
      end
      exp_q.push_back({{ACC_W{1'b0}}, sb, 1'b0});
      return;
    end
    if (!mul)     t = longint'({b, a});
    else if (sgn) t = longint'($signed(a)) * longint'($signed(b));
    else          t = longint'(a) * longint'(b);
    t = wrap_acc(t);
    if (accum) begin
      r = sub ? (acc_m[sel] - t) : (acc_m[sel] + t);
      if (r > MAXV || r < MINV) begin
        ovf_m[sel] = 1'b1;
        if (SATURATE != 0) r = (r > MAXV) ? MAXV : MINV;
        else               r = wrap_acc(r);
      end
      acc_m[sel] = r;
    end else begin
      acc_m[sel] = t;
    end
    r = acc_m[sel];
    exp_q.push_back({r[ACC_W-1:0], sb, ovf_m[sel]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_ready();
    if (bp_mode == 0)      out_ready = 1'b1;
    else if (bp_mode == 2) out_ready = 1'b0;
    else                   out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      drive_ready();
    end
  endtask

  // Leaves in_valid high on return; the caller follows with another send or idle.
  task automatic send_op(input logic [15:0] a, input logic [15:0] b, input int sel,
                         input logic sgn, input logic mul, input logic rac,
                         input logic accum, input logic sub);
    int  waited;
    bit  done;
    waited = 0;
    done   = 0;
    @(negedge clk);
    drive_ready();
    input_a = a; input_b = b; acc_sel = SEL_W'(sel);
    is_signed = sgn; mult_enabled = mul; reset_accum = rac;
    accumulate = accum; add_or_sub = sub;
    in_valid = 1'b1;
    while (!done) begin
      #1;
      if (in_ready) begin
        model_issue(a, b, sel, sgn, mul, rac, accum, sub);
        done = 1;
      end else begin
        waited++;
        if (waited > 200) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: got in_ready=0 for %0d cycles required 1", waited);
          done = 1;
        end else begin
          @(negedge clk);
          drive_ready();
        end
      end
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got acc=%0h sel=%0d ovf=%0b required no result",
                   output_acc, out_sel, overflow);
        end else begin
          exp = exp_q.pop_front();
          check("result{acc,sel,ovf}", 64'({output_acc, out_sel, overflow}), 64'(exp));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [ACC_W-1:0] held;
    bp_mode = 0;
    in_valid = 0; input_a = '0; input_b = '0; acc_sel = '0;
    is_signed = 0; mult_enabled = 0; reset_accum = 0; accumulate = 0; add_or_sub = 0;
    out_ready = 1'b1;
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_output_acc", 64'(output_acc), 64'(0));
    check("rst_out_sel", 64'(out_sel), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    rst_n = 1'b1;
    #1 check("in_ready_before_edge", 64'(in_ready), 64'(0));
    @(negedge clk);
    #1 check("in_ready_after_edge", 64'(in_ready), 64'(1));

    // 3 * -4 signed load, with latency measured in cycles
    send_op(16'd3, 16'hFFFC, 0, 1, 1, 0, 0, 0);
    n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
      #1;
    end while (!out_valid && n < 10);
    check("latency", 64'(n), 64'(3));
    idle(3);

    // clear then four back-to-back accumulations of 0x100*0x10
    send_op(16'h0, 16'h0, 0, 0, 1, 1, 0, 0);
    repeat (4) send_op(16'h0100, 16'h0010, 0, 0, 1, 0, 1, 0);
    idle(5);

    // interleaved independent accumulators
    send_op(16'h0, 16'h0, 0, 0, 1, 1, 0, 0);
    send_op(16'h0, 16'h0, 1, 0, 1, 1, 0, 0);
    repeat (2) begin
      send_op(16'd5, 16'd5, 0, 1, 1, 0, 1, 0);
      send_op(16'hFFFE, 16'd7, 1, 1, 1, 0, 1, 1);
    end
    idle(5);

    // saturation near the positive rail, then clear
    send_op(16'hFFF0, 16'h7FFF, 0, 0, 0, 0, 0, 0);
    send_op(16'h0010, 16'h0010, 0, 0, 1, 0, 1, 0);
    send_op(16'h0, 16'h0, 0, 0, 1, 1, 0, 0);
    idle(5);

    // backpressure with three ops in flight, including a pass-through load
    bp_mode = 2;
    send_op(16'd9, 16'd9, 0, 0, 1, 0, 0, 0);
    send_op(16'h1234, 16'hABCD, 1, 0, 0, 0, 0, 0);
    send_op(16'd2, 16'd3, 0, 0, 1, 0, 1, 0);
    idle(1);
    #1;
    held = exp_q[0][EW-1 -: ACC_W];
    for (int i = 0; i < 5; i++) begin
      idle(1);
      #1;
      check("stall_in_ready", 64'(in_ready), 64'(0));
      check("stall_output_acc", 64'(output_acc), 64'(held));
    end
    bp_mode = 0;
    idle(6);

    // out-of-range select consumed with zero result
    send_op(16'd7, 16'd7, 3, 0, 1, 0, 1, 0);
    idle(4);

    // randomized ops with random backpressure
    bp_mode = 1;
    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, NUM_ACC - 1));
      send_op(16'($urandom), 16'($urandom), sel, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    bp_mode = 0;
    idle(1);
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      idle(1);
      n++;
    end
    check("drain_random", 64'(exp_q.size()), 64'(0));

    // reset with two ops in flight
    send_op(16'd4, 16'd4, 0, 0, 1, 0, 1, 0);
    send_op(16'd6, 16'd6, 1, 0, 1, 0, 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_output_acc", 64'(output_acc), 64'(0));
    exp_q.delete();
    model_reset();
    idle(3);
    #1 rst_n = 1'b1;
    idle(10);
    send_op(16'd2, 16'd3, 0, 0, 1, 0, 1, 0);
    idle(1);
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      idle(1);
      n++;
    end
    check("drain_final", 64'(exp_q.size()), 64'(0));
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
